// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Exports the FSM state enum, matrix size and column-decode helpers.
package keypad_scan_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_CONFIRM,
      ST_HELD
   } state_e;

   // Exactly one column pulled low.
   function automatic logic one_zero(input logic [COLS-1:0] c);
      return $countones(~c) == 1;
   endfunction

   // Index of the low column (meaningful only when one_zero is true).
   function automatic logic [1:0] zero_idx(input logic [COLS-1:0] c);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < COLS; i++) begin
         if (!c[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan-rate tick generator: one-clk pulse every CLK_HZ/SCAN_HZ clocks.
// Ports: clk, rst (sync, active-high) in; tick out (registered).
module scan_tick #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
      if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce; one key_valid per press.
// Ports: clk, rst, key_col[3:0] in; key_row[3:0], key_valid, key_code[3:0], key_held out.
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_col,
   output logic [3:0] key_row,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);
   localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

   logic tick;

   scan_tick #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   logic [3:0] col_m_q, col_s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_m_q <= 4'hF;
         col_s_q <= 4'hF;
      end else begin
         col_m_q <= key_col;
         col_s_q <= col_m_q;
      end
   end

   state_e        state_q, state_d;
   logic [1:0]    row_q, row_d;
   logic [1:0]    cand_row_q, cand_row_d;
   logic [1:0]    cand_col_q, cand_col_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rel_q, rel_d;
   logic [3:0]    key_row_q, key_row_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_held_q, key_held_d;
   logic [3:0]    cand_pat;

   assign cand_pat = ~(4'b0001 << cand_col_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         cand_row_q <= '0;
         cand_col_q <= '0;
         cnt_q      <= '0;
         rel_q      <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         cand_row_q <= cand_row_d;
         cand_col_q <= cand_col_d;
         cnt_q      <= cnt_d;
         rel_q      <= rel_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cand_row_d = cand_row_q;
      cand_col_d = cand_col_q;
      cnt_d      = cnt_q;
      rel_d      = rel_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            rel_d = '0;
            if (tick && col_s_q != 4'hF) begin
               state_d = ST_SCAN;
               row_d   = '0;
            end
         end
         ST_SCAN: begin
            if (tick) begin
               if (one_zero(col_s_q)) begin
                  state_d    = ST_CONFIRM;
                  cand_row_d = row_q;
                  cand_col_d = zero_idx(col_s_q);
                  cnt_d      = CW'(1);
               end else if (row_q == LAST_ROW) begin
                  state_d = ST_IDLE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         ST_CONFIRM: begin
            if (tick) begin
               if (col_s_q != cand_pat) begin
                  state_d = ST_IDLE;
               end else if (cnt_q + 1'b1 >= DB) begin
                  cnt_d   = DB;
                  rel_d   = '0;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_HELD: begin
            // Only the accepted column matters; other keys are ignored.
            if (tick) begin
               if (!col_s_q[cand_col_q]) begin
                  rel_d = '0;
               end else if (rel_q + 1'b1 >= DB) begin
                  rel_d   = DB;
                  state_d = ST_IDLE;
               end else begin
                  rel_d = rel_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so the registered
   // outputs line up with the state register.
   always_comb begin
      key_row_d   = 4'hF;
      key_valid_d = (state_q == ST_CONFIRM) && (state_d == ST_HELD);
      key_code_d  = key_valid_d ? {cand_row_q, cand_col_q} : key_code_q;
      key_held_d  = (state_d == ST_HELD);
      unique case (state_d)
         ST_IDLE:    key_row_d = 4'b0000;
         ST_SCAN:    key_row_d = ~(4'b0001 << row_d);
         ST_CONFIRM: key_row_d = ~(4'b0001 << cand_row_d);
         ST_HELD:    key_row_d = ~(4'b0001 << cand_row_d);
         default:    key_row_d = 4'hF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_row_q   <= 4'hF;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_held_q  <= 1'b0;
      end else begin
         key_row_q   <= key_row_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
      end
   end

   assign key_row   = key_row_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: behavioural 4x4 matrix, vector table
// plus hand sequences for bounce, hold, ghost and reset cases.
module tb_keypad_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_col;
   logic [3:0]  key_row;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] keys;

   int n_cmp = 0;
   int n_err = 0;
   int vcount = 0;
   int cyc = 0;
   int last_cyc = 0;

   always #5 clk = ~clk;

   keypad_scan #(
      .CLK_HZ         (1000),
      .SCAN_HZ        (100),
      .DEBOUNCE_SCANS (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_col   (key_col),
      .key_row   (key_row),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held)
   );

   // Matrix: a pressed key pulls its column low when its row is driven low.
   always_comb begin
      key_col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
   end

   always @(posedge clk) begin
      if (key_valid) begin
         vcount   = vcount + 1;
         last_cyc = cyc;
      end
      cyc = cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      string       name;
      logic [15:0] keys;
      int          hold;
      int          pulses;
      int          code;
      int          max_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base;
      int pc;
      vecs[0] = '{"r2c1",      16'h0200, 200, 1, 9,  2+10*7+10};
      vecs[1] = '{"r0c0",      16'h0001, 100, 1, 0,  2+10*5+10};
      vecs[2] = '{"r3c3",      16'h8000, 120, 1, 15, 2+10*8+10};
      vecs[3] = '{"r1c2",      16'h0040, 100, 1, 6,  2+10*6+10};
      vecs[4] = '{"glitch",    16'h0010, 15,  0, 6,  0};
      vecs[5] = '{"ghost",     16'h5000, 150, 0, 6,  0};
      vecs[6] = '{"two_rows",  16'h0802, 120, 1, 1,  2+10*5+10};

      rst  = 1'b1;
      keys = '0;
      wait_clks(3);
      check("rst_row",   int'(key_row),   15);
      check("rst_valid", int'(key_valid), 0);
      check("rst_code",  int'(key_code),  0);
      check("rst_held",  int'(key_held),  0);
      rst = 1'b0;
      wait_clks(1);
      check("idle_row", int'(key_row), 0);
      wait_clks(20);

      for (int i = 0; i < 7; i++) begin
         base = vcount;
         pc   = cyc;
         keys = vecs[i].keys;
         wait_clks(vecs[i].hold);
         check({vecs[i].name, "_pulses"}, vcount - base, vecs[i].pulses);
         check({vecs[i].name, "_code"}, int'(key_code), vecs[i].code);
         check({vecs[i].name, "_held"}, int'(key_held),
               (vecs[i].pulses > 0) ? 1 : 0);
         if (vecs[i].pulses > 0)
            check({vecs[i].name, "_lat_ok"},
                  (last_cyc - pc <= vecs[i].max_lat) ? 1 : 0, 1);
         keys = '0;
         wait_clks(100);
         check({vecs[i].name, "_rel_pulses"}, vcount - base, vecs[i].pulses);
         check({vecs[i].name, "_rel_held"}, int'(key_held), 0);
         check({vecs[i].name, "_idle_row"}, int'(key_row), 0);
      end

      // Bounce on row0/col3, then solid.
      base = vcount;
      for (int i = 0; i < 9; i++) begin
         keys[3] = ~keys[3];
         wait_clks(7);
      end
      check("bounce_none", vcount - base, 0);
      keys = 16'h0008;
      wait_clks(120);
      check("bounce_pulses", vcount - base, 1);
      check("bounce_code", int'(key_code), 3);
      keys = '0;
      wait_clks(100);

      // Hold row3/col2, add row0/col0; second key only after release.
      base = vcount;
      keys = 16'h4000;
      wait_clks(120);
      check("hold_pulses", vcount - base, 1);
      check("hold_code", int'(key_code), 14);
      keys = 16'h4001;
      wait_clks(150);
      check("hold_extra_none", vcount - base, 1);
      check("hold_extra_held", int'(key_held), 1);
      check("hold_extra_code", int'(key_code), 14);
      keys = 16'h0001;
      wait_clks(150);
      check("after_rel_pulses", vcount - base, 2);
      check("after_rel_code", int'(key_code), 0);
      keys = '0;
      wait_clks(100);

      // Reset while held; key stays down and is re-detected.
      keys = 16'h0200;
      wait_clks(120);
      check("pre_rst_held", int'(key_held), 1);
      base = vcount;
      rst  = 1'b1;
      wait_clks(1);
      check("mid_rst_held", int'(key_held), 0);
      check("mid_rst_row", int'(key_row), 15);
      wait_clks(1);
      check("mid_rst_code", int'(key_code), 0);
      rst = 1'b0;
      wait_clks(120);
      check("redetect_pulses", vcount - base, 1);
      check("redetect_code", int'(key_code), 9);
      check("redetect_held", int'(key_held), 1);
      keys = '0;
      wait_clks(100);
      check("final_held", int'(key_held), 0);
      check("final_pulses", vcount - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
